// File: rtl/cpu_defs.sv
// Shared definitions for the fetch front end: word size, bubble encoding, fetch states, IF/ID layout.
package cpu_defs;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HELD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction
endpackage

// File: rtl/pc_register.sv
// Program counter: holds the fetch PC, provides PC+4 (wrapping), and applies redirects over increments.
module pc_register
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            inc_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o
);
  logic [XLEN-1:0] pc_q, pc_d;

  assign pc_o  = pc_q;
  assign pc4_o = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i)
      pc_d = word_align(target_i);
    else if (inc_i)
      pc_d = pc4_o;
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      pc_q <= word_align(RESET_PC);
    else
      pc_q <= pc_d;
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage with IF/ID register: issues word reads over a busy handshake,
// parks a completed word while decode is stalled, and squashes in-flight reads on redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  output logic        imem_read_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_busy_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] ifid_pc_out,
  output logic [31:0] ifid_pc4_out,
  output logic [31:0] ifid_instr_out,
  output logic        ifid_valid_out,
  output logic        fetch_stall_out
);
  import cpu_defs::*;

  fetch_state_e state_q, state_d;
  logic         read_q, read_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  disc_addr_q, disc_addr_d;
  ifid_t        ifid_q, ifid_d;
  logic         pc_inc, pc_redirect;
  logic [31:0]  pc, pc4;
  logic         complete, waiting;

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .CLK        (CLK),
    .RESET      (RESET),
    .inc_i      (pc_inc),
    .redirect_i (pc_redirect),
    .target_i   (branch_target_in),
    .pc_o       (pc),
    .pc4_o      (pc4)
  );

  assign complete = read_q & ~imem_busy_in;
  assign waiting  = read_q & imem_busy_in;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    disc_addr_d = disc_addr_q;
    ifid_d      = ifid_q;
    pc_inc      = 1'b0;
    pc_redirect = 1'b0;
    if (branch_taken_in) begin
      pc_redirect  = 1'b1;
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
      // An unfinished read must still run to completion at its old address.
      if (waiting) begin
        state_d = DISCARD;
        if (state_q == FETCH)
          disc_addr_d = pc;
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (complete) begin
            if (stall_in) begin
              buf_d   = imem_rdata_in;
              state_d = HELD;
            end else begin
              ifid_d = {pc, pc4, imem_rdata_in, 1'b1};
              pc_inc = 1'b1;
            end
          end
        end
        HELD: begin
          if (!stall_in) begin
            ifid_d  = {pc, pc4, buf_q, 1'b1};
            pc_inc  = 1'b1;
            state_d = FETCH;
          end
        end
        DISCARD: begin
          if (complete)
            state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
    read_d = (state_d != HELD);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= FETCH;
      read_q      <= 1'b0;
      buf_q       <= '0;
      disc_addr_q <= '0;
      ifid_q      <= {32'h0, 32'h0, NOP_INSTR, 1'b0};
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      buf_q       <= buf_d;
      disc_addr_q <= disc_addr_d;
      ifid_q      <= ifid_d;
    end
  end

  assign imem_read_out   = read_q;
  assign imem_addr_out   = (state_q == DISCARD) ? disc_addr_q : pc;
  assign fetch_stall_out = (state_q != HELD) & waiting;
  assign ifid_pc_out     = ifid_q.pc;
  assign ifid_pc4_out    = ifid_q.pc4;
  assign ifid_instr_out  = ifid_q.instr;
  assign ifid_valid_out  = ifid_q.valid;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: wait-state memory model, directed scenarios and a randomized run
// against a transaction-level reference model.
module tb_instruction_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        stall_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic [31:0] branch_target_in = 32'h0;
  logic        imem_read_out, imem_busy_in, ifid_valid_out, fetch_stall_out;
  logic [31:0] imem_addr_out, imem_rdata_in, ifid_pc_out, ifid_pc4_out, ifid_instr_out;
  logic        w_read, w_valid, w_stall;
  logic [31:0] w_addr, w_rdata, w_pc, w_pc4, w_instr;

  int n_chk = 0;
  int n_fail = 0;
  int mcnt = 0;
  int ws_fixed = 0;
  int ws_rand = 0;
  bit rand_ws = 1'b0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_busy_in  = imem_read_out && (mcnt < (rand_ws ? ws_rand : ws_fixed));
  assign imem_rdata_in = mem_word(imem_addr_out);
  assign w_rdata       = mem_word(w_addr);

  always @(posedge CLK) begin
    if (RESET) mcnt <= 0;
    else if (imem_read_out) begin
      if (imem_busy_in) mcnt <= mcnt + 1;
      else begin
        mcnt <= 0;
        if (rand_ws) ws_rand <= int'($urandom_range(0, 3));
      end
    end
  end

  instruction_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .stall_in(stall_in), .branch_taken_in(branch_taken_in),
    .branch_target_in(branch_target_in), .imem_read_out(imem_read_out), .imem_addr_out(imem_addr_out),
    .imem_busy_in(imem_busy_in), .imem_rdata_in(imem_rdata_in), .ifid_pc_out(ifid_pc_out),
    .ifid_pc4_out(ifid_pc4_out), .ifid_instr_out(ifid_instr_out), .ifid_valid_out(ifid_valid_out),
    .fetch_stall_out(fetch_stall_out)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .CLK(CLK), .RESET(RESET), .stall_in(stall_in), .branch_taken_in(branch_taken_in),
    .branch_target_in(branch_target_in), .imem_read_out(w_read), .imem_addr_out(w_addr),
    .imem_busy_in(1'b0), .imem_rdata_in(w_rdata), .ifid_pc_out(w_pc),
    .ifid_pc4_out(w_pc4), .ifid_instr_out(w_instr), .ifid_valid_out(w_valid),
    .fetch_stall_out(w_stall)
  );

  // Reference model of the main instance, one update per clock edge.
  bit          m_read = 1'b0, m_valid = 1'b0, m_drop = 1'b0;
  logic [31:0] m_pc = 32'h0, m_addr = 32'h0, m_ipc = 32'h0, m_ipc4 = 32'h0, m_instr = NOP;
  logic [31:0] m_hold[$];

  task automatic model_step();
    bit done;
    done = m_read && !imem_busy_in;
    if (RESET) begin
      m_pc = 32'h0; m_read = 1'b0; m_valid = 1'b0; m_instr = NOP;
      m_ipc = 32'h0; m_ipc4 = 32'h0; m_drop = 1'b0; m_hold.delete();
    end else if (branch_taken_in) begin
      m_pc = {branch_target_in[31:2], 2'b00};
      if (m_read && imem_busy_in) m_drop = 1'b1;
      else begin m_drop = 1'b0; m_addr = m_pc; end
      m_valid = 1'b0; m_instr = NOP; m_hold.delete(); m_read = 1'b1;
    end else if (m_hold.size() != 0) begin
      if (!stall_in) begin
        m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = m_hold.pop_front(); m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_read = 1'b1; m_addr = m_pc;
      end
    end else if (!m_read) begin
      m_read = 1'b1; m_addr = m_pc;
    end else if (done) begin
      if (m_drop) begin m_drop = 1'b0; m_addr = m_pc; end
      else if (stall_in) begin m_hold.push_back(mem_word(m_addr)); m_read = 1'b0; end
      else begin
        m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = mem_word(m_addr); m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_addr = m_pc;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1; stall_in = 1'b0; branch_taken_in = 1'b0;
    tick(); tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    ws_fixed = 0; rand_ws = 1'b0;
    do_reset();
    n_chk++; if (imem_read_out !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %b want 0", imem_read_out); end
    n_chk++; if (ifid_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ifid_valid_out); end
    n_chk++; if (ifid_instr_out !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h want %h", ifid_instr_out, NOP); end
    n_chk++; if (ifid_pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", ifid_pc_out); end
    n_chk++; if (ifid_pc4_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc4: got %h want 0", ifid_pc4_out); end
    n_chk++; if (fetch_stall_out !== 1'b0) begin n_fail++; $display("FAIL rst_fstall: got %b want 0", fetch_stall_out); end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] ea, ep;
    ws_fixed = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick();
      ea = 32'(i - 1) * 32'd4;
      ep = 32'(i - 2) * 32'd4;
      n_chk++; if (imem_read_out !== 1'b1 || imem_addr_out !== ea) begin
        n_fail++; $display("FAIL seq_addr[%0d]: got read=%b addr=%h want read=1 addr=%h", i, imem_read_out, imem_addr_out, ea); end
      n_chk++; if (ifid_valid_out !== (i >= 2)) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want %b", i, ifid_valid_out, (i >= 2)); end
      if (i >= 2) begin
        n_chk++; if (ifid_pc_out !== ep || ifid_instr_out !== mem_word(ep)) begin
          n_fail++; $display("FAIL seq_ifid[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, ifid_pc_out, ifid_instr_out, ep, mem_word(ep)); end
      end
    end
  endtask

  task automatic test_wait_states();
    ws_fixed = 3;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_chk++; if (imem_addr_out !== 32'h0 || imem_read_out !== 1'b1) begin n_fail++; $display("FAIL ws_hold[%0d]: got addr=%h read=%b want 0/1", i, imem_addr_out, imem_read_out); end
      n_chk++; if (fetch_stall_out !== (i <= 3)) begin n_fail++; $display("FAIL ws_fstall[%0d]: got %b want %b", i, fetch_stall_out, (i <= 3)); end
      n_chk++; if (ifid_valid_out !== 1'b0) begin n_fail++; $display("FAIL ws_novalid[%0d]: got %b want 0", i, ifid_valid_out); end
    end
    tick();
    n_chk++; if (imem_addr_out !== 32'h4 || ifid_valid_out !== 1'b1 || ifid_pc_out !== 32'h0 || ifid_instr_out !== mem_word(32'h0)) begin
      n_fail++; $display("FAIL ws_load: got addr=%h v=%b pc=%h instr=%h want 4/1/0/%h", imem_addr_out, ifid_valid_out, ifid_pc_out, ifid_instr_out, mem_word(32'h0)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (ifid_pc_out !== 32'h0) begin n_fail++; $display("FAIL ws_oneload[%0d]: got pc=%h want 0", i, ifid_pc_out); end
    end
    tick();
    n_chk++; if (ifid_pc_out !== 32'h4 || ifid_pc4_out !== 32'h8) begin n_fail++; $display("FAIL ws_second: got pc=%h pc4=%h want 4/8", ifid_pc_out, ifid_pc4_out); end
  endtask

  task automatic test_stall_held();
    ws_fixed = 0;
    do_reset();
    tick(); tick(); tick();
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (imem_read_out !== 1'b0) begin n_fail++; $display("FAIL held_read[%0d]: got %b want 0", i, imem_read_out); end
      n_chk++; if (ifid_pc_out !== 32'h4 || ifid_valid_out !== 1'b1) begin n_fail++; $display("FAIL held_ifid[%0d]: got pc=%h v=%b want 4/1", i, ifid_pc_out, ifid_valid_out); end
    end
    stall_in = 1'b0;
    tick();
    n_chk++; if (ifid_pc_out !== 32'h8 || ifid_instr_out !== mem_word(32'h8)) begin n_fail++; $display("FAIL held_release: got pc=%h instr=%h want 8/%h", ifid_pc_out, ifid_instr_out, mem_word(32'h8)); end
    n_chk++; if (imem_read_out !== 1'b1 || imem_addr_out !== 32'hC) begin n_fail++; $display("FAIL held_next: got read=%b addr=%h want 1/c", imem_read_out, imem_addr_out); end
  endtask

  task automatic test_branch_discard();
    int guard;
    ws_fixed = 2;
    do_reset();
    tick(); tick(); tick(); tick();
    branch_taken_in = 1'b1; branch_target_in = 32'h103;
    tick();
    branch_taken_in = 1'b0;
    n_chk++; if (ifid_valid_out !== 1'b0 || ifid_instr_out !== NOP) begin n_fail++; $display("FAIL br_bubble: got v=%b instr=%h want 0/%h", ifid_valid_out, ifid_instr_out, NOP); end
    n_chk++; if (imem_read_out !== 1'b1 || imem_addr_out !== 32'h4) begin n_fail++; $display("FAIL br_addrhold: got read=%b addr=%h want 1/4", imem_read_out, imem_addr_out); end
    guard = 0;
    while (imem_addr_out === 32'h4 && guard < 8) begin
      tick(); guard++;
      n_chk++; if (ifid_valid_out !== 1'b0) begin n_fail++; $display("FAIL br_dropped[%0d]: got v=%b want 0", guard, ifid_valid_out); end
    end
    n_chk++; if (guard != 2 || imem_addr_out !== 32'h100) begin n_fail++; $display("FAIL br_target: got addr=%h after %0d cycles want 100 after 2", imem_addr_out, guard); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_chk++; if (ifid_valid_out !== (i == 3)) begin n_fail++; $display("FAIL br_newvalid[%0d]: got %b want %b", i, ifid_valid_out, (i == 3)); end
    end
    n_chk++; if (ifid_pc_out !== 32'h100 || ifid_instr_out !== mem_word(32'h100)) begin n_fail++; $display("FAIL br_newword: got pc=%h instr=%h want 100/%h", ifid_pc_out, ifid_instr_out, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_stall();
    ws_fixed = 0;
    do_reset();
    tick(); tick(); tick();
    stall_in = 1'b1;
    tick();
    n_chk++; if (imem_read_out !== 1'b0) begin n_fail++; $display("FAIL rs_held: got read=%b want 0", imem_read_out); end
    branch_taken_in = 1'b1; branch_target_in = 32'h200;
    tick();
    branch_taken_in = 1'b0;
    n_chk++; if (ifid_valid_out !== 1'b0 || ifid_instr_out !== NOP) begin n_fail++; $display("FAIL rs_bubble: got v=%b instr=%h want 0/%h", ifid_valid_out, ifid_instr_out, NOP); end
    n_chk++; if (imem_read_out !== 1'b1 || imem_addr_out !== 32'h200) begin n_fail++; $display("FAIL rs_target: got read=%b addr=%h want 1/200", imem_read_out, imem_addr_out); end
    stall_in = 1'b0;
    tick();
    n_chk++; if (ifid_valid_out !== 1'b1 || ifid_pc_out !== 32'h200 || ifid_instr_out !== mem_word(32'h200)) begin
      n_fail++; $display("FAIL rs_after: got v=%b pc=%h instr=%h want 1/200/%h", ifid_valid_out, ifid_pc_out, ifid_instr_out, mem_word(32'h200)); end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] ea;
    ws_fixed = 3;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      ea = 32'hFFFF_FFF8 + 32'(i - 1) * 32'd4;
      n_chk++; if (w_read !== 1'b1 || w_addr !== ea) begin n_fail++; $display("FAIL wrap_addr[%0d]: got read=%b addr=%h want 1/%h", i, w_read, w_addr, ea); end
    end
    n_chk++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0 || w_instr !== mem_word(32'hFFFF_FFFC) || w_stall !== 1'b0) begin
      n_fail++; $display("FAIL wrap_ifid: got v=%b pc=%h pc4=%h instr=%h fs=%b want 1/fffffffc/0/%h/0", w_valid, w_pc, w_pc4, w_instr, w_stall, mem_word(32'hFFFF_FFFC)); end
    n_chk++; if (imem_read_out !== 1'b1 || fetch_stall_out !== 1'b1) begin n_fail++; $display("FAIL midwait_pre: got read=%b fs=%b want 1/1", imem_read_out, fetch_stall_out); end
    RESET = 1'b1;
    tick();
    n_chk++; if (imem_read_out !== 1'b0 || fetch_stall_out !== 1'b0) begin n_fail++; $display("FAIL midwait_read: got read=%b fs=%b want 0/0", imem_read_out, fetch_stall_out); end
    n_chk++; if (ifid_valid_out !== 1'b0 || ifid_instr_out !== NOP || ifid_pc_out !== 32'h0 || ifid_pc4_out !== 32'h0) begin
      n_fail++; $display("FAIL midwait_ifid: got v=%b instr=%h pc=%h pc4=%h want 0/%h/0/0", ifid_valid_out, ifid_instr_out, ifid_pc_out, ifid_pc4_out, NOP); end
    RESET = 1'b0;
    tick();
    n_chk++; if (imem_read_out !== 1'b1 || imem_addr_out !== 32'h0) begin n_fail++; $display("FAIL midwait_restart: got read=%b addr=%h want 1/0", imem_read_out, imem_addr_out); end
  endtask

  task automatic test_random();
    bit br_prev;
    rand_ws = 1'b1;
    do_reset();
    br_prev = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      stall_in = ($urandom_range(0, 3) == 0);
      branch_taken_in = !br_prev && ($urandom_range(0, 11) == 0);
      branch_target_in = $urandom;
      br_prev = branch_taken_in;
      tick();
      n_chk++; if (imem_read_out !== m_read) begin n_fail++; $display("FAIL rnd_read@%0d: got %b want %b", c, imem_read_out, m_read); end
      if (m_read) begin
        n_chk++; if (imem_addr_out !== m_addr) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", c, imem_addr_out, m_addr); end
      end
      n_chk++; if (ifid_valid_out !== m_valid || ifid_instr_out !== m_instr) begin
        n_fail++; $display("FAIL rnd_ifid@%0d: got v=%b instr=%h want v=%b instr=%h", c, ifid_valid_out, ifid_instr_out, m_valid, m_instr); end
      if (m_valid) begin
        n_chk++; if (ifid_pc_out !== m_ipc || ifid_pc4_out !== m_ipc4) begin
          n_fail++; $display("FAIL rnd_pc@%0d: got pc=%h pc4=%h want %h/%h", c, ifid_pc_out, ifid_pc4_out, m_ipc, m_ipc4); end
      end
      n_chk++; if (fetch_stall_out !== (m_read && imem_busy_in)) begin
        n_fail++; $display("FAIL rnd_fstall@%0d: got %b want %b", c, fetch_stall_out, (m_read && imem_busy_in)); end
    end
    stall_in = 1'b0; branch_taken_in = 1'b0; rand_ws = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_wait_states();
    test_stall_held();
    test_branch_discard();
    test_redirect_stall();
    test_wrap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
